// File: rtl/rans_pkg.sv
// Shared rANS definitions: default widths, the state-width helper used by both
// encoder and decoder, and the decoder FSM state type.
package rans_pkg;

  localparam int RANS_RESOLUTION   = 10;
  localparam int RANS_SYMBOL_WIDTH = 8;

  function automatic int rans_state_width(input int resolution, input int symbol_width);
    return resolution + symbol_width;
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_LOOK,
    ST_FETCH,
    ST_CALC,
    ST_EMIT,
    ST_RENORM
  } rans_dec_state_e;

endpackage

// File: rtl/rans_dec_tables.sv
// Decoder tables: per-symbol {freq,cum} table and slot-to-symbol table, both with
// registered reads, plus the down-counter that walks slots while a symbol is filled.
module rans_dec_tables
  import rans_pkg::*;
#(
  parameter int RESOLUTION   = RANS_RESOLUTION,
  parameter int SYMBOL_WIDTH = RANS_SYMBOL_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [SYMBOL_WIDTH-1:0] wr_sym,
  input  logic [RESOLUTION-1:0]   wr_freq,
  input  logic [RESOLUTION-1:0]   wr_cum,
  input  logic                    fill_en,
  output logic                    fill_last,
  input  logic                    slot_rd_en,
  input  logic [RESOLUTION-1:0]   slot_addr,
  output logic [SYMBOL_WIDTH-1:0] slot_sym,
  input  logic                    freq_rd_en,
  input  logic [SYMBOL_WIDTH-1:0] freq_addr,
  output logic [RESOLUTION-1:0]   rd_freq,
  output logic [RESOLUTION-1:0]   rd_cum
);

  logic [2*RESOLUTION-1:0] freq_mem [2**SYMBOL_WIDTH];
  logic [SYMBOL_WIDTH-1:0] slot_mem [2**RESOLUTION];

  logic [RESOLUTION-1:0]   fill_ptr;
  logic [RESOLUTION-1:0]   fill_cnt;
  logic [SYMBOL_WIDTH-1:0] fill_sym;

  // Table contents survive reset so a host need not reload them.
  always_ff @(posedge clk) begin
    if (wr_en)   freq_mem[wr_sym]   <= {wr_freq, wr_cum};
    if (fill_en) slot_mem[fill_ptr] <= fill_sym;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      fill_ptr <= wr_cum;
      fill_cnt <= wr_freq;
      fill_sym <= wr_sym;
    end else if (fill_en) begin
      fill_ptr <= fill_ptr + RESOLUTION'(1);
      fill_cnt <= fill_cnt - RESOLUTION'(1);
    end
  end

  assign fill_last = (fill_cnt == RESOLUTION'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_sym <= '0;
      rd_freq  <= '0;
      rd_cum   <= '0;
    end else begin
      if (slot_rd_en) slot_sym <= slot_mem[slot_addr];
      if (freq_rd_en) {rd_freq, rd_cum} <= freq_mem[freq_addr];
    end
  end

endmodule

// File: rtl/rans_dec.sv
// Streaming rANS decoder: one symbol per LOOK/FETCH/CALC/EMIT/RENORM pass.
// Optional RANS_DEC_SYM_CNT_EN adds a 32-bit handshake counter on sym_cnt_o.
//
// state  | meaning
// IDLE   | accept table writes, init and run
// FILL   | write one slot per cycle for the last configured symbol
// LOOK   | read symbol from slot table at state & mask
// FETCH  | read {freq,cum} of that symbol
// CALC   | state = f*(state>>R) + (state&mask) - c
// EMIT   | present symbol until ready_i
// RENORM | shift in bytes until state >= L_MIN
module rans_dec
  import rans_pkg::*;
#(
  parameter int  RESOLUTION   = RANS_RESOLUTION,
  parameter int  SYMBOL_WIDTH = RANS_SYMBOL_WIDTH,
  localparam int STATE_WIDTH  = rans_state_width(RESOLUTION, SYMBOL_WIDTH)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    freq_wr_i,
  input  logic [SYMBOL_WIDTH-1:0] symb_i,
  input  logic [RESOLUTION-1:0]   freq_i,
  input  logic [RESOLUTION-1:0]   cum_freq_i,
  output logic                    cfg_ready_o,
  input  logic                    init_i,
  input  logic [STATE_WIDTH-1:0]  init_state_i,
  input  logic                    run_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [SYMBOL_WIDTH-1:0] in_data_i,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [SYMBOL_WIDTH-1:0] symb_o,
  output logic [STATE_WIDTH-1:0]  state_o
`ifdef RANS_DEC_SYM_CNT_EN
  ,
  output logic [31:0]             sym_cnt_o
`endif
);

  localparam logic [STATE_WIDTH-1:0] L_MIN = STATE_WIDTH'(1) << RESOLUTION;

  rans_dec_state_e fsm_q, fsm_d;
  logic [STATE_WIDTH-1:0]  st_q, st_d;
  logic [STATE_WIDTH-1:0]  prod, calc;
  logic                    tbl_wr_en;
  logic                    fill_last;
  logic [SYMBOL_WIDTH-1:0] slot_sym;
  logic [RESOLUTION-1:0]   rd_freq, rd_cum;

  rans_dec_tables #(
    .RESOLUTION  (RESOLUTION),
    .SYMBOL_WIDTH(SYMBOL_WIDTH)
  ) u_tables (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .wr_en     (tbl_wr_en),
    .wr_sym    (symb_i),
    .wr_freq   (freq_i),
    .wr_cum    (cum_freq_i),
    .fill_en   (fsm_q == ST_FILL),
    .fill_last (fill_last),
    .slot_rd_en(fsm_q == ST_LOOK),
    .slot_addr (st_q[RESOLUTION-1:0]),
    .slot_sym  (slot_sym),
    .freq_rd_en(fsm_q == ST_FETCH),
    .freq_addr (slot_sym),
    .rd_freq   (rd_freq),
    .rd_cum    (rd_cum)
  );

  // Product of a RESOLUTION-bit freq and SYMBOL_WIDTH-bit quotient fits the state width.
  assign prod = STATE_WIDTH'(rd_freq) * STATE_WIDTH'(st_q[STATE_WIDTH-1:RESOLUTION]);
  assign calc = prod + STATE_WIDTH'(st_q[RESOLUTION-1:0]) - STATE_WIDTH'(rd_cum);

  always_comb begin
    fsm_d     = fsm_q;
    st_d      = st_q;
    tbl_wr_en = 1'b0;
    case (fsm_q)
      ST_IDLE: begin
        if (freq_wr_i) begin
          tbl_wr_en = 1'b1;
          if (freq_i != '0) fsm_d = ST_FILL;
        end else if (init_i) begin
          st_d = init_state_i;
          if (run_i) fsm_d = ST_LOOK;
        end else if (run_i) begin
          fsm_d = ST_LOOK;
        end
      end
      ST_FILL:  if (fill_last) fsm_d = ST_IDLE;
      ST_LOOK:  fsm_d = ST_FETCH;
      ST_FETCH: fsm_d = ST_CALC;
      ST_CALC: begin
        st_d  = calc;
        fsm_d = ST_EMIT;
      end
      ST_EMIT:  if (ready_i) fsm_d = ST_RENORM;
      ST_RENORM: begin
        if (st_q >= L_MIN) begin
          fsm_d = run_i ? ST_LOOK : ST_IDLE;
        end else if (in_valid_i) begin
          st_d = {st_q[STATE_WIDTH-SYMBOL_WIDTH-1:0], in_data_i};
        end
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      fsm_q <= ST_IDLE;
      st_q  <= L_MIN;
    end else begin
      fsm_q <= fsm_d;
      st_q  <= st_d;
    end
  end

  assign cfg_ready_o = (fsm_q == ST_IDLE);
  assign valid_o     = (fsm_q == ST_EMIT);
  assign in_ready_o  = (fsm_q == ST_RENORM) && (st_q < L_MIN);
  assign symb_o      = slot_sym;
  assign state_o     = st_q;

`ifdef RANS_DEC_SYM_CNT_EN
  logic [31:0] sym_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sym_cnt_q <= '0;
    end else if (fsm_q == ST_IDLE && !freq_wr_i && init_i) begin
      sym_cnt_q <= '0;
    end else if (valid_o && ready_i) begin
      sym_cnt_q <= sym_cnt_q + 32'd1;
    end
  end

  assign sym_cnt_o = sym_cnt_q;
`endif

endmodule

// File: tb/tb_rans_dec.sv
// Scoreboard bench for rans_dec: a slot/frequency model predicts symbols and final
// states; a monitor pops expected symbols on every output handshake.
module tb_rans_dec;

  logic        clk;
  logic        rst_ni;
  logic        freq_wr_i;
  logic [7:0]  symb_i;
  logic [9:0]  freq_i;
  logic [9:0]  cum_freq_i;
  logic        cfg_ready_o;
  logic        init_i;
  logic [17:0] init_state_i;
  logic        run_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [7:0]  in_data_i;
  logic        valid_o;
  logic        ready_i;
  logic [7:0]  symb_o;
  logic [17:0] state_o;
`ifdef RANS_DEC_SYM_CNT_EN
  logic [31:0] sym_cnt_o;
`endif

  rans_dec dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .freq_wr_i   (freq_wr_i),
    .symb_i      (symb_i),
    .freq_i      (freq_i),
    .cum_freq_i  (cum_freq_i),
    .cfg_ready_o (cfg_ready_o),
    .init_i      (init_i),
    .init_state_i(init_state_i),
    .run_i       (run_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .symb_o      (symb_o),
    .state_o     (state_o)
`ifdef RANS_DEC_SYM_CNT_EN
    ,
    .sym_cnt_o   (sym_cnt_o)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  int          freq_m [256];
  int          cum_m  [256];
  int          slot_m [1024];
  logic [7:0]  bytes  [64];
  logic [7:0]  exp_q  [$];

  int   bidx = 0;
  int   hs_count = 0;
  bit   feed_en = 0;
  bit   rnd_bp = 0;
  bit   rdy_auto = 1;
  bit   saw_in_ready = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Output monitor: scoreboard pop on handshake, stability check while stalled.
  bit         pend = 0;
  logic [7:0] pend_sym = '0;
  always @(negedge clk) begin
    if (!rst_ni) begin
      pend = 0;
    end else begin
      if (pend) begin
        chk("hold_valid", {31'd0, valid_o}, 32'd1);
        chk("hold_symb", {24'd0, symb_o}, {24'd0, pend_sym});
      end
      pend     = valid_o && !ready_i;
      pend_sym = symb_o;
      if (valid_o && ready_i) begin
        hs_count++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_symbol actual=0x%0h required=none", symb_o);
        end else begin
          chk("symb", {24'd0, symb_o}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  // Byte source: presents bytes[bidx] with random gaps, advances on handshake.
  initial begin
    bit take;
    in_valid_i = 1'b0;
    in_data_i  = '0;
    forever begin
      @(negedge clk);
      take = in_valid_i && in_ready_o;
      if (in_ready_o) saw_in_ready = 1;
      @(posedge clk);
      #1;
      if (take) bidx++;
      in_valid_i = feed_en && (bidx < 64) && ($urandom_range(0, 3) != 0);
      in_data_i  = (bidx < 64) ? bytes[bidx] : 8'h00;
    end
  end

  initial begin
    ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_auto) ready_i = rnd_bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Reference model: plain rANS arithmetic over the configured tables.
  task automatic model_decode(input int init, input int n, output int fin, output int pre,
                              output int used);
    int x, s;
    x    = init;
    used = 0;
    pre  = init;
    for (int i = 0; i < n; i++) begin
      s = slot_m[x % 1024];
      exp_q.push_back(8'(s));
      x   = (freq_m[s] * (x / 1024) + (x % 1024) - cum_m[s]) & 32'h3FFFF;
      pre = x;
      while (x < 1024 && used < 64) begin
        x = (x * 256 + int'(bytes[used])) & 32'h3FFFF;
        used++;
      end
    end
    fin = x;
  endtask

  task automatic cfg(input int s, input int f, input int c);
    int n;
    n = 0;
    while (!cfg_ready_o && n < 2000) begin step(); n++; end
    freq_wr_i  = 1'b1;
    symb_i     = 8'(s);
    freq_i     = 10'(f);
    cum_freq_i = 10'(c);
    step();
    freq_wr_i = 1'b0;
    freq_m[s] = f;
    cum_m[s]  = c;
    for (int k = 0; k < f; k++) slot_m[(c + k) % 1024] = s;
    n = 0;
    while (!cfg_ready_o && n < 2000) begin n++; step(); end
    chk($sformatf("fill_len_%0h", s), n, f);
  endtask

  task automatic rand_bytes();
    for (int i = 0; i < 64; i++) bytes[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic decode(input int init, input int n, input bit bp, input bit lat);
    int fin, pre, used, cyc;
    model_decode(init, n, fin, pre, used);
    bidx         = 0;
    saw_in_ready = 0;
    hs_count     = 0;
    rnd_bp       = bp;
    feed_en      = 1;
    init_state_i = 18'(init);
    init_i       = 1'b1;
    run_i        = 1'b1;
    step();
    init_i = 1'b0;
    if (lat) begin
      for (int i = 0; i < 3; i++) begin
        chk("latency_early", {31'd0, valid_o}, 32'd0);
        step();
      end
      chk("latency_valid", {31'd0, valid_o}, 32'd1);
    end
    cyc = 0;
    while (hs_count < n && cyc < 5000) begin step(); cyc++; end
    chk("decode_timeout", hs_count, n);
    run_i = 1'b0;
    cyc = 0;
    while (!cfg_ready_o && cyc < 200) begin step(); cyc++; end
    chk("idle_timeout", {31'd0, cfg_ready_o}, 32'd1);
    chk($sformatf("final_state_%0h", init), {14'd0, state_o}, fin);
    chk("bytes_used", bidx, used);
    chk("queue_empty", exp_q.size(), 0);
`ifdef RANS_DEC_SYM_CNT_EN
    chk("sym_cnt", sym_cnt_o, hs_count);
`endif
    feed_en = 0;
    rnd_bp  = 0;
  endtask

  task automatic rand_table();
    int k, base, acc, f, s;
    k    = $urandom_range(3, 8);
    base = $urandom_range(0, 255);
    acc  = 0;
    for (int i = 0; i < k; i++) begin
      s = (base + i * 37) % 256;
      f = (i == k - 1) ? 1024 - acc : $urandom_range(1, (1024 - acc) / 2);
      cfg(s, f, acc);
      acc += f;
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int fin, pre, used, cyc;
    rst_ni       = 1'b0;
    freq_wr_i    = 1'b0;
    symb_i       = '0;
    freq_i       = '0;
    cum_freq_i   = '0;
    init_i       = 1'b0;
    init_state_i = '0;
    run_i        = 1'b0;
    for (int i = 0; i < 1024; i++) slot_m[i] = 0;
    for (int i = 0; i < 256; i++) begin freq_m[i] = 0; cum_m[i] = 0; end
    rand_bytes();
    step();
    step();
    rst_ni = 1'b1;
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready_o}, 32'd0);
    chk("rst_cfg_ready", {31'd0, cfg_ready_o}, 32'd1);
    chk("rst_state", {14'd0, state_o}, 32'h400);
    chk("rst_symb", {24'd0, symb_o}, 32'd0);

    cfg(8'h41, 512, 0);
    cfg(8'h42, 512, 512);
    cfg(8'h60, 0, 100);
    decode(18'h400, 1, 0, 0);
    decode(18'h5FF, 1, 0, 0);
    decode(18'h600, 1, 0, 0);
    decode(18'h7FF, 1, 0, 0);

    decode(18'h2200, 1, 0, 1);
    chk("no_renorm_in_ready", {31'd0, saw_in_ready}, 32'd0);

    rand_bytes();
    bytes[0] = 8'hAB;
    decode(18'h400, 1, 0, 0);

    cfg(8'h41, 511, 0);
    cfg(8'h43, 1, 511);
    cfg(8'h42, 512, 512);
    bytes[0] = 8'h01;
    bytes[1] = 8'h02;
    decode(18'h5FF, 1, 0, 0);

    // Output stall, input stall, then reset mid-renormalization.
    rdy_auto = 0;
    ready_i  = 1'b0;
    feed_en  = 0;
    hs_count = 0;
    model_decode(18'h400, 1, fin, pre, used);
    init_state_i = 18'h400;
    init_i = 1'b1;
    run_i  = 1'b1;
    step();
    init_i = 1'b0;
    cyc = 0;
    while (!valid_o && cyc < 50) begin step(); cyc++; end
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'd0, valid_o}, 32'd1);
      step();
    end
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    run_i   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_in_ready", {31'd0, in_ready_o}, 32'd1);
      chk("stall_state", {14'd0, state_o}, pre);
      step();
    end
    chk("stall_hs", hs_count, 1);
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    chk("rst2_valid", {31'd0, valid_o}, 32'd0);
    chk("rst2_in_ready", {31'd0, in_ready_o}, 32'd0);
    chk("rst2_cfg_ready", {31'd0, cfg_ready_o}, 32'd1);
    chk("rst2_state", {14'd0, state_o}, 32'h400);
    rdy_auto = 1;
    rand_bytes();
    decode(18'h5FF, 1, 0, 0);
    decode(18'h400, 3, 1, 0);

    // Slot index wrap during fill.
    cfg(8'h55, 4, 1022);
    decode(18'h401, 1, 0, 0);
    decode(18'h7FE, 1, 0, 0);

    for (int t = 0; t < 2; t++) begin
      rand_table();
      for (int d = 0; d < 3; d++) begin
        rand_bytes();
        decode($urandom_range(1024, 262143), $urandom_range(6, 14), 1, 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
